encode_quad_sampler: RTL and testbench

Upstream feeder for encode_process. It decodes the raw wafer-rotation (W, with index Z) and linear-stage (X) quadrature encoder signals into 20-bit position counters. It samples both counters on a fixed cycle period and presents them as encode_update_o / encode_w_o / encode_x_o. These outputs connect directly to encode_process encode_update_i / encode_w_i / encode_x_i.

---
 rtl/encode_pkg.sv | 43 ++++
 rtl/quad_channel_filter.sv | 57 +++++
 rtl/encode_quad_sampler.sv | 119 +++++++++++
 tb/tb_encode_quad_sampler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encode_pkg.sv
// Shared constants and x4 quadrature decode for the encoder sampler.
// Step codes, default counter width, and the (prev AB, cur AB) -> step lookup.
package encode_pkg;

    localparam int ENCODE_WID_DEF = 20;

    localparam logic [1:0] QUAD_STEP_NONE = 2'd0;
    localparam logic [1:0] QUAD_STEP_UP   = 2'd1;
    localparam logic [1:0] QUAD_STEP_DOWN = 2'd2;
    localparam logic [1:0] QUAD_STEP_ERR  = 2'd3;

    // Position of an {A,B} pair along the 00->01->11->10 cycle.
    function automatic logic [1:0] quad_idx(input logic [1:0] ab);
        logic [1:0] idx;
        idx = 2'd0;
        unique case (ab)
            2'b00: idx = 2'd0;
            2'b01: idx = 2'd1;
            2'b11: idx = 2'd2;
            2'b10: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Phase distance of 2 means both bits flipped: direction unknown.
    function automatic logic [1:0] quad_step(
        input logic [1:0] prev_ab,
        input logic [1:0] cur_ab
    );
        logic [1:0] d;
        logic [1:0] st;
        d  = quad_idx(cur_ab) - quad_idx(prev_ab);
        st = QUAD_STEP_NONE;
        unique case (d)
            2'd0: st = QUAD_STEP_NONE;
            2'd1: st = QUAD_STEP_UP;
            2'd2: st = QUAD_STEP_ERR;
            2'd3: st = QUAD_STEP_DOWN;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/quad_channel_filter.sv
// One encoder channel: synchroniser, glitch filter and x4 step decode.
// Ports: clk_i, rst_n_i, i_a/i_b/i_z raw inputs; o_step code, o_z_rise pulse.
module quad_channel_filter
    import encode_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_z,
    output logic [1:0] o_step,
    output logic       o_z_rise
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Bit order everywhere: {A, B, Z}.
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  w_sync;
    logic [2:0]                  r_filt;
    logic [2:0]                  r_prev;
    logic [CW-1:0]               r_cnt [3];

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
            r_filt <= '0;
            r_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {i_a, i_b, i_z}};
            r_prev <= r_filt;
            // Accept a new level only after FILTER_LEN differing cycles.
            for (int i = 0; i < 3; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= w_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_step   = quad_step(r_prev[2:1], r_filt[2:1]);
    assign o_z_rise = r_filt[0] & ~r_prev[0];

endmodule

// File: rtl/encode_quad_sampler.sv
// W/X quadrature position counters with periodic sampling for encode_process.
// Ports: raw w_a/w_b/w_z, x_a/x_b; sample_en_i, err_clr_i; sampled outputs.
module encode_quad_sampler
    import encode_pkg::*;
#(
    parameter int ENCODE_WID    = ENCODE_WID_DEF,
    parameter int SAMPLE_PERIOD = 4000,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  w_a_i,
    input  logic                  w_b_i,
    input  logic                  w_z_i,
    input  logic                  x_a_i,
    input  logic                  x_b_i,
    input  logic                  sample_en_i,
    input  logic                  err_clr_i,
    output logic                  encode_update_o,
    output logic [ENCODE_WID-1:0] encode_w_o,
    output logic [ENCODE_WID-1:0] encode_x_o,
    output logic                  w_zero_o,
    output logic [1:0]            quad_err_o
);

    localparam int TW = $clog2(SAMPLE_PERIOD);

    logic [1:0]            w_w_step;
    logic [1:0]            w_x_step;
    logic                  w_w_zrise;
    logic                  w_tick;
    logic [ENCODE_WID-1:0] r_w_cnt;
    logic [ENCODE_WID-1:0] r_x_cnt;
    logic [TW-1:0]         r_timer;

    quad_channel_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_w_chan (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_a      (w_a_i),
        .i_b      (w_b_i),
        .i_z      (w_z_i),
        .o_step   (w_w_step),
        .o_z_rise (w_w_zrise)
    );

    quad_channel_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_x_chan (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_a      (x_a_i),
        .i_b      (x_b_i),
        .i_z      (1'b0),
        .o_step   (w_x_step),
        .o_z_rise ()
    );

    assign w_tick = sample_en_i && (r_timer == TW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_w_cnt         <= '0;
            r_x_cnt         <= '0;
            r_timer         <= '0;
            encode_update_o <= 1'b0;
            encode_w_o      <= '0;
            encode_x_o      <= '0;
            w_zero_o        <= 1'b0;
            quad_err_o      <= '0;
        end else begin
            // Index beats any simultaneous W step.
            if (w_w_zrise) begin
                r_w_cnt <= '0;
            end else if (w_w_step == QUAD_STEP_UP) begin
                r_w_cnt <= r_w_cnt + 1'b1;
            end else if (w_w_step == QUAD_STEP_DOWN) begin
                r_w_cnt <= r_w_cnt - 1'b1;
            end

            if (w_x_step == QUAD_STEP_UP) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end else if (w_x_step == QUAD_STEP_DOWN) begin
                r_x_cnt <= r_x_cnt - 1'b1;
            end

            w_zero_o <= w_w_zrise;

            if (!sample_en_i || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            encode_update_o <= w_tick;
            if (w_tick) begin
                encode_w_o <= r_w_cnt;
                encode_x_o <= r_x_cnt;
            end

            // Set has priority over clear.
            if (w_w_step == QUAD_STEP_ERR) begin
                quad_err_o[0] <= 1'b1;
            end else if (err_clr_i) begin
                quad_err_o[0] <= 1'b0;
            end
            if (w_x_step == QUAD_STEP_ERR) begin
                quad_err_o[1] <= 1'b1;
            end else if (err_clr_i) begin
                quad_err_o[1] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encode_quad_sampler.sv
// Randomised self-checking bench for encode_quad_sampler.
// Model tracks encoder phase and position as plain integers.
module tb_encode_quad_sampler;

    localparam int P   = 100;
    localparam int WID = 20;

    logic           clk = 1'b0;
    logic           rst_n_i = 1'b0;
    logic           w_a_i = 1'b0;
    logic           w_b_i = 1'b0;
    logic           w_z_i = 1'b0;
    logic           x_a_i = 1'b0;
    logic           x_b_i = 1'b0;
    logic           sample_en_i = 1'b0;
    logic           err_clr_i = 1'b0;
    logic           encode_update_o;
    logic [WID-1:0] encode_w_o;
    logic [WID-1:0] encode_x_o;
    logic           w_zero_o;
    logic [1:0]     quad_err_o;

    int n_chk = 0;
    int n_bad = 0;

    // Model: phase index 0..3 along 00,01,11,10 and wrapped positions.
    int             pw = 0;
    int             px = 0;
    logic [WID-1:0] mw = '0;
    logic [WID-1:0] mx = '0;

    always #5 clk = ~clk;

    encode_quad_sampler #(
        .SAMPLE_PERIOD (P)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .w_a_i           (w_a_i),
        .w_b_i           (w_b_i),
        .w_z_i           (w_z_i),
        .x_a_i           (x_a_i),
        .x_b_i           (x_b_i),
        .sample_en_i     (sample_en_i),
        .err_clr_i       (err_clr_i),
        .encode_update_o (encode_update_o),
        .encode_w_o      (encode_w_o),
        .encode_x_o      (encode_x_o),
        .w_zero_o        (w_zero_o),
        .quad_err_o      (quad_err_o)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ph_ab(input int ph);
        logic [1:0] t [4];
        t[0] = 2'b00;
        t[1] = 2'b01;
        t[2] = 2'b11;
        t[3] = 2'b10;
        return t[ph];
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_w(input int dir, input int h);
        pw = (pw + dir + 4) % 4;
        mw = mw + WID'(dir);
        {w_a_i, w_b_i} = ph_ab(pw);
        hold(h);
    endtask

    task automatic step_x(input int dir, input int h);
        px = (px + dir + 4) % 4;
        mx = mx + WID'(dir);
        {x_a_i, x_b_i} = ph_ab(px);
        hold(h);
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        for (int i = 0; i < 4 * P; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (encode_update_o) break;
        end
        if (!encode_update_o) chk("strobe_timeout", 0, 1);
    endtask

    task automatic chk_sample(input string tag);
        int c;
        hold(12);
        wait_strobe(c);
        chk({tag, "_w"}, encode_w_o, mw);
        chk({tag, "_x"}, encode_x_o, mx);
    endtask

    initial begin
        int c;
        int first;
        int pulses;
        int k;
        int d;

        // Reset state.
        #23;
        chk("rst_upd", encode_update_o, 0);
        chk("rst_w", encode_w_o, 0);
        chk("rst_err", quad_err_o, 0);
        @(negedge clk);
        rst_n_i = 1'b1;
        hold(3);
        sample_en_i = 1'b1;
        wait_strobe(c);
        chk("first_strobe_lat", c, P);
        chk("first_w", encode_w_o, 0);
        chk("first_x", encode_x_o, 0);
        wait_strobe(c);
        chk("strobe_spacing", c, P);

        // Forward then reverse W.
        for (int i = 0; i < 40; i++) step_w(1, 20);
        chk_sample("fwd40");
        for (int i = 0; i < 12; i++) step_w(-1, 20);
        chk_sample("rev12");

        // X wrap at zero.
        step_x(-1, 20);
        chk_sample("x_under");
        step_x(1, 20);
        step_x(1, 20);
        chk_sample("x_over");

        // Short glitch is filtered.
        @(negedge clk);
        w_a_i = ~w_a_i;
        hold(2);
        w_a_i = ~w_a_i;
        chk_sample("glitch");
        chk("glitch_err", quad_err_o, 0);

        // Both phases flip: illegal, count held.
        pw = (pw + 2) % 4;
        {w_a_i, w_b_i} = ph_ab(pw);
        chk_sample("illegal");
        chk("illegal_err", quad_err_o, 2'b01);
        hold(30);
        chk("err_sticky", quad_err_o, 2'b01);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("err_clr", quad_err_o, 0);

        // Disable suppresses strobes; re-enable restarts the period.
        sample_en_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk);
            #1;
            if (encode_update_o) pulses++;
        end
        chk("dis_no_strobe", pulses, 0);
        @(negedge clk);
        sample_en_i = 1'b1;
        wait_strobe(c);
        chk("reen_lat", c, P);

        // Random mixed motion.
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, 24);
            for (int i = 0; i < k; i++) begin
                d = ($urandom_range(0, 1) == 1) ? 1 : -1;
                if ($urandom_range(0, 1) == 1) begin
                    step_w(d, $urandom_range(6, 15));
                end else begin
                    step_x(d, $urandom_range(6, 15));
                end
            end
            chk_sample("rand");
            chk("rand_err", quad_err_o, 0);
        end

        // Index pulse at W=500.
        while (mw != WID'(500)) begin
            if (mw < WID'(500) || mw > WID'(600000)) step_w(1, 7);
            else step_w(-1, 7);
        end
        chk_sample("w500");
        first = 0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            w_z_i = (i < 10);
            @(posedge clk);
            #1;
            if (w_zero_o) begin
                pulses++;
                if (first == 0) first = i + 1;
            end
        end
        chk("zero_lat", first, 7);
        chk("zero_pulses", pulses, 1);
        mw = '0;
        k = $urandom_range(3, 12);
        for (int i = 0; i < k; i++) step_w(1, 10);
        chk_sample("after_index");

        // Asynchronous reset mid-period.
        while (pw != 0) step_w(1, 10);
        while (px != 0) step_x(1, 10);
        if (mx == 0) begin
            for (int i = 0; i < 4; i++) step_x(1, 10);
        end
        chk_sample("pre_rst");
        hold(40);
        @(posedge clk);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("arst_w", encode_w_o, 0);
        chk("arst_x", encode_x_o, 0);
        chk("arst_err", quad_err_o, 0);
        chk("arst_upd", encode_update_o, 0);
        mw = '0;
        mx = '0;
        @(negedge clk);
        rst_n_i = 1'b1;
        wait_strobe(c);
        chk("post_rst_lat", c, P);
        chk("post_rst_w", encode_w_o, 0);
        chk("post_rst_x", encode_x_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
